// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard control bundle: hazard-detection inputs from the datapath
// and stage-register enables/flushes/status back to it.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ack;

  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_bubble;
  logic             state;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_memread, ex_rd,
           ex_branch_taken, mem_req, mem_ack,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
           id_ex_flush, mem_wb_bubble, state, mem_timeout_err, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_memread, ex_rd,
           ex_branch_taken, mem_req, mem_ack,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
           id_ex_flush, mem_wb_bubble, state, mem_timeout_err, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: memory-wait freeze, branch flush and
// load-use stall, with memory timeout flag and saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT == 0) ? '0 : WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WAIT_W-1:0] r_wait;
  logic             r_err;
  logic [CNT_W-1:0] r_stall;

  logic w_mem_busy;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_use;
  logic w_pc_en;
  logic w_if_id_en;
  logic w_id_ex_en;
  logic w_ex_mem_en;
  logic w_mem_wb_en;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_mem_wb_bubble;

  assign w_mem_busy = bus.mem_req & ~bus.mem_ack;
  assign w_rs1_hit  = bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd);
  assign w_rs2_hit  = bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd);
  assign w_load_use = bus.ex_memread & (bus.ex_rd != '0) & (w_rs1_hit | w_rs2_hit);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RUN:      if (w_mem_busy)  w_next = MEM_WAIT;
      MEM_WAIT: if (bus.mem_ack) w_next = RUN;
      default:  w_next = RUN;
    endcase
  end

  // Reset gates the Mealy outputs so the pipeline is frozen while rst_n is low.
  always_comb begin
    w_pc_en         = 1'b0;
    w_if_id_en      = 1'b0;
    w_id_ex_en      = 1'b0;
    w_ex_mem_en     = 1'b0;
    w_mem_wb_en     = 1'b0;
    w_if_id_flush   = 1'b0;
    w_id_ex_flush   = 1'b0;
    w_mem_wb_bubble = 1'b0;
    if (rst_n) begin
      if (w_mem_busy) begin
        w_mem_wb_en     = 1'b1;
        w_mem_wb_bubble = 1'b1;
      end else if (bus.ex_branch_taken) begin
        w_pc_en       = 1'b1;
        w_if_id_en    = 1'b1;
        w_id_ex_en    = 1'b1;
        w_ex_mem_en   = 1'b1;
        w_mem_wb_en   = 1'b1;
        w_if_id_flush = 1'b1;
        w_id_ex_flush = 1'b1;
      end else if (w_load_use) begin
        w_id_ex_en    = 1'b1;
        w_ex_mem_en   = 1'b1;
        w_mem_wb_en   = 1'b1;
        w_id_ex_flush = 1'b1;
      end else begin
        w_pc_en     = 1'b1;
        w_if_id_en  = 1'b1;
        w_id_ex_en  = 1'b1;
        w_ex_mem_en = 1'b1;
        w_mem_wb_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_next;
  end

  // Error sets on the edge that completes the MEM_TIMEOUT-th MEM_WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else if (r_state == RUN) begin
      if (w_mem_busy) r_wait <= '0;
    end else begin
      if (r_wait != WAIT_MAX)  r_wait <= r_wait + 1'b1;
      if (r_wait >= WAIT_LAST) r_err  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_stall <= '0;
    else if (!w_pc_en && r_stall != '1) r_stall <= r_stall + 1'b1;
  end

  assign bus.pc_en           = w_pc_en;
  assign bus.if_id_en        = w_if_id_en;
  assign bus.id_ex_en        = w_id_ex_en;
  assign bus.ex_mem_en       = w_ex_mem_en;
  assign bus.mem_wb_en       = w_mem_wb_en;
  assign bus.if_id_flush     = w_if_id_flush;
  assign bus.id_ex_flush     = w_id_ex_flush;
  assign bus.mem_wb_bubble   = w_mem_wb_bubble;
  assign bus.state           = r_state;
  assign bus.mem_timeout_err = r_err;
  assign bus.stall_cycles    = r_stall;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazard priorities, memory wait,
// timeout, asynchronous reset mid-wait and stall-counter saturation.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CW = 6;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_bubble}
  localparam logic [7:0] C_ZERO   = 8'b00000_000;
  localparam logic [7:0] C_NORMAL = 8'b11111_000;
  localparam logic [7:0] C_MEM    = 8'b00001_001;
  localparam logic [7:0] C_BRANCH = 8'b11111_110;
  localparam logic [7:0] C_LDUSE  = 8'b00111_010;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ctl();
    return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
            bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_bubble};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle();
    bus.id_rs1          = '0;
    bus.id_rs2          = '0;
    bus.id_uses_rs1     = 1'b0;
    bus.id_uses_rs2     = 1'b0;
    bus.ex_memread      = 1'b0;
    bus.ex_rd           = '0;
    bus.ex_branch_taken = 1'b0;
    bus.mem_req         = 1'b0;
    bus.mem_ack         = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    #12;
    chk("rst_ctl",   32'(ctl()), 32'(C_ZERO));
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_err",   32'(bus.mem_timeout_err), 0);
    chk("rst_stall", 32'(bus.stall_cycles), 0);
    rst_n = 1'b1;

    tick(); settle();
    chk("norm_ctl",   32'(ctl()), 32'(C_NORMAL));
    chk("norm_stall", 32'(bus.stall_cycles), 0);

    // Load-use on rs2
    tick();
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_uses_rs2 = 1'b1;
    settle();
    chk("lu2_ctl", 32'(ctl()), 32'(C_LDUSE));
    tick(); idle(); settle();
    chk("lu2_after_ctl",   32'(ctl()), 32'(C_NORMAL));
    chk("lu2_after_stall", 32'(bus.stall_cycles), 1);

    // rs1 match but not used, then used
    tick();
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7;
    settle();
    chk("lu1_unused_ctl", 32'(ctl()), 32'(C_NORMAL));
    bus.id_uses_rs1 = 1'b1;
    #1;
    chk("lu1_ctl", 32'(ctl()), 32'(C_LDUSE));
    tick(); idle(); settle();
    chk("lu1_after_stall", 32'(bus.stall_cycles), 2);

    // Load into x0
    tick();
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_uses_rs1 = 1'b1;
    settle();
    chk("x0_ctl", 32'(ctl()), 32'(C_NORMAL));
    tick(); idle(); settle();
    chk("x0_stall", 32'(bus.stall_cycles), 2);

    // Branch plus load-use
    tick();
    bus.ex_branch_taken = 1'b1;
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_uses_rs2 = 1'b1;
    settle();
    chk("br_lu_ctl", 32'(ctl()), 32'(C_BRANCH));
    tick(); idle(); settle();
    chk("br_lu_stall", 32'(bus.stall_cycles), 2);

    // Memory wait: ack low three cycles, then high
    tick(); bus.mem_req = 1'b1; settle();
    chk("mw1_ctl",   32'(ctl()), 32'(C_MEM));
    chk("mw1_state", 32'(bus.state), 0);
    tick(); settle();
    chk("mw2_ctl",   32'(ctl()), 32'(C_MEM));
    chk("mw2_state", 32'(bus.state), 1);
    tick(); settle();
    chk("mw3_ctl",   32'(ctl()), 32'(C_MEM));
    chk("mw3_state", 32'(bus.state), 1);
    tick(); bus.mem_ack = 1'b1; settle();
    chk("mw_ack_ctl",   32'(ctl()), 32'(C_NORMAL));
    chk("mw_ack_state", 32'(bus.state), 1);
    chk("mw_ack_stall", 32'(bus.stall_cycles), 5);
    tick(); idle(); settle();
    chk("mw_done_state", 32'(bus.state), 0);
    chk("mw_done_ctl",   32'(ctl()), 32'(C_NORMAL));

    // Memory busy plus branch: stall first, branch honoured on ack
    tick(); bus.mem_req = 1'b1; bus.ex_branch_taken = 1'b1; settle();
    chk("mb_br_ctl", 32'(ctl()), 32'(C_MEM));
    tick(); bus.mem_ack = 1'b1; settle();
    chk("mb_br_ack_ctl",   32'(ctl()), 32'(C_BRANCH));
    chk("mb_br_ack_state", 32'(bus.state), 1);
    tick(); idle(); settle();
    chk("mb_br_done_state", 32'(bus.state), 0);
    chk("mb_br_done_stall", 32'(bus.stall_cycles), 6);

    // Timeout: 20 busy cycles
    tick(); bus.mem_req = 1'b1; settle();
    chk("to_c1_err", 32'(bus.mem_timeout_err), 0);
    for (int i = 2; i <= 20; i++) begin
      tick(); settle();
      chk("to_state", 32'(bus.state), 1);
      chk("to_err",   32'(bus.mem_timeout_err), (i >= 17) ? 1 : 0);
    end
    chk("to_stall", 32'(bus.stall_cycles), 25);
    tick(); bus.mem_ack = 1'b1; settle();
    chk("to_ack_ctl", 32'(ctl()), 32'(C_NORMAL));
    tick(); idle(); settle();
    chk("to_after_state", 32'(bus.state), 0);
    chk("to_after_err",   32'(bus.mem_timeout_err), 1);
    chk("to_after_stall", 32'(bus.stall_cycles), 26);

    // Asynchronous reset in MEM_WAIT
    tick(); bus.mem_req = 1'b1;
    tick(); settle();
    chk("rmw_state_pre", 32'(bus.state), 1);
    rst_n = 1'b0;
    #1;
    chk("rmw_ctl",   32'(ctl()), 32'(C_ZERO));
    chk("rmw_state", 32'(bus.state), 0);
    chk("rmw_err",   32'(bus.mem_timeout_err), 0);
    chk("rmw_stall", 32'(bus.stall_cycles), 0);
    idle();
    #2;
    rst_n = 1'b1;
    tick(); settle();
    chk("rmw_rel_ctl",   32'(ctl()), 32'(C_NORMAL));
    chk("rmw_rel_state", 32'(bus.state), 0);

    // Stall counter saturation at 2^CW-1
    tick(); bus.mem_req = 1'b1; settle();
    for (int i = 2; i <= 70; i++) begin
      tick(); settle();
      if (i == 63)             chk("sat_62", 32'(bus.stall_cycles), 62);
      if (i == 64 || i == 70)  chk("sat_63", 32'(bus.stall_cycles), 63);
    end
    tick(); bus.mem_ack = 1'b1; settle();
    chk("sat_ack_stall", 32'(bus.stall_cycles), 63);
    tick(); idle(); settle();
    chk("sat_done_stall", 32'(bus.stall_cycles), 63);
    chk("sat_done_ctl",   32'(ctl()), 32'(C_NORMAL));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameters SHALL be, one per line: name, default, meaning.
- MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before the error flag sets.
- CNT_W, 16, width of the stall counter.

REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, async active-low reset.
- id_rs1 / id_rs2, in, 5 each, ID-stage source registers.
- id_uses_rs1 / id_uses_rs2, in, 1 each, ID instruction reads that source.
- ex_memread, in, 1, ID/EX MemRead.
- ex_rd, in, 5, ID/EX rd.
- ex_branch_taken, in, 1, EX resolved taken branch/jal/jalr.
- mem_req, in, 1, EX/MEM MemRead|MemWrite.
- mem_ack, in, 1, data memory completes this cycle.
- pc_en / if_id_en / id_ex_en / ex_mem_en / mem_wb_en, out, 1 each, stage-register load enables.
- if_id_flush / id_ex_flush, out, 1 each, load a bubble (all control fields 0).
- mem_wb_bubble, out, 1, MEM/WB loads a bubble.
- state, out, 1, 0=RUN, 1=MEM_WAIT.
- mem_timeout_err, out, 1, sticky error flag.
- stall_cycles, out, CNT_W, saturating count of cycles with pc_en=0.

Function
REQ-004 The FSM SHALL have states RUN and MEM_WAIT.
- mem_busy = mem_req & ~mem_ack.
- RUN goes to MEM_WAIT when mem_busy.
- MEM_WAIT goes to RUN on the first cycle mem_ack=1.
REQ-005 Outputs SHALL be combinational (Mealy) from state and inputs, with priority memory stall > branch flush > load-use > normal.
REQ-006 Memory stall, when mem_busy in either state:
- pc_en, if_id_en, id_ex_en and ex_mem_en SHALL be 0.
- mem_wb_en=1 and mem_wb_bubble=1.
- Both flushes SHALL be 0.
REQ-007 Branch flush, when ex_branch_taken and not mem_busy:
- All enables SHALL be 1.
- if_id_flush=1 and id_ex_flush=1.
REQ-008 Load-use, when ex_memread & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)):
- pc_en=0 and if_id_en=0.
- id_ex_flush=1 and id_ex_en=1.
- ex_mem_en=1 and mem_wb_en=1.
REQ-009 Load-use stall SHALL last exactly one cycle per hazard; the bubble clears ex_memread on the next cycle.
REQ-010 Normal operation: all enables SHALL be 1, and flushes and bubble SHALL be 0.
REQ-011 A simultaneous branch and load-use SHALL resolve as branch flush only, because the ID instruction is wrong-path.
REQ-012 A simultaneous mem_busy and branch SHALL resolve as memory stall.
- The branch SHALL then be honoured on the cycle mem_ack=1, since EX is frozen and ex_branch_taken is held.
REQ-013 A wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle.
- When it reaches MEM_TIMEOUT, mem_timeout_err SHALL set and stay set until reset.
- The FSM SHALL remain in MEM_WAIT until mem_ack.
REQ-014 stall_cycles SHALL increment on each clock with pc_en=0.
- It SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-015 ex_rd=0 SHALL never cause a load-use stall.

Reset
REQ-016 While rst_n=0, asynchronously:
- state SHALL be RUN.
- The wait counter, stall_cycles and mem_timeout_err SHALL be 0.
- All enables, flushes and mem_wb_bubble SHALL be forced to 0.
REQ-017 Reset asserted during MEM_WAIT SHALL abort the wait; the first cycle after release SHALL be RUN with normal outputs if inputs are idle.

Verification
REQ-018 The bench SHALL cover these directed scenarios.
- Load-use: ex_memread=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles goes 0->1.
- x0 load: ex_memread=1, ex_rd=0, id_rs1=0, id_uses_rs1=1 -> normal outputs, no stall.
- Branch plus load-use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1.
- Memory wait: mem_req=1 with mem_ack low for 3 cycles, then high -> state=1 for 3 cycles, then RUN.
  - Freeze enables 0 for 3 cycles and mem_wb_bubble=1.
  - stall_cycles rises by 3.
- Timeout: mem_req=1 with mem_ack=0 for 20 cycles -> mem_timeout_err=1 after 15 MEM_WAIT cycles, still set after the ack.
- Reset in MEM_WAIT: assert rst_n=0 mid-wait -> state=0, err=0, counter=0, all outputs 0 immediately (asynchronous).
